// File: rtl/iec_sd_arb_pkg.sv
// Shared types and helpers for the IEC drive SD-channel arbiter.
// Build option: IEC_SD_ARB_TIMEOUT_EN enables the host ack watchdog in iec_sd_arbiter.
package iec_sd_arb_pkg;

   localparam int MAX_DRIVES = 4;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      XFER,
      REL
   } arb_state_e;

   typedef struct packed {
      logic       found;
      logic [1:0] idx;
   } rr_pick_t;

   function automatic int clamp_drives(input int drives);
      if (drives < 1) return 1;
      if (drives > MAX_DRIVES) return MAX_DRIVES;
      return drives;
   endfunction

   // Scans from ptr upward (mod ndr); walking offsets high-to-low leaves the nearest pending lane in res.
   function automatic rr_pick_t rr_pick(input logic [3:0] pending, input logic [1:0] ptr, input int ndr);
      rr_pick_t res;
      int       lane;
      res = '0;
      for (int k = MAX_DRIVES - 1; k >= 0; k--) begin
         if (k < ndr) begin
            lane = (int'(ptr) + k) % ndr;
            if (pending[lane[1:0]]) begin
               res.found = 1'b1;
               res.idx   = lane[1:0];
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/iec_sd_arbiter_rr_picker.sv
// Combinational round-robin priority encoder over up to MAX_DRIVES requesters.
// Shared by the SD-channel arbiter and intended for reuse by other lane arbiters.
module iec_sd_rr_picker
   import iec_sd_arb_pkg::*;
#(
   parameter int NDR = 4
) (
   input  logic [MAX_DRIVES-1:0] pending_i,
   input  logic [1:0]            ptr_i,
   output logic                  found_o,
   output logic [1:0]            idx_o
);

   rr_pick_t pick;

   always_comb begin
      pick    = rr_pick(pending_i, ptr_i, NDR);
      found_o = pick.found;
      idx_o   = pick.idx;
   end

endmodule

// File: rtl/iec_sd_arbiter.sv
// Round-robin arbiter sharing one host SD sector channel among up to four drive lanes.
// Build option: IEC_SD_ARB_TIMEOUT_EN adds a watchdog that aborts a request the host never acks.
module iec_sd_arbiter
   import iec_sd_arb_pkg::*;
#(
   parameter int  DRIVES    = 2,
   parameter int  TIMEOUT_W = 24,
   localparam int NDR       = clamp_drives(DRIVES)
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic [32*NDR-1:0] req_lba,
   input  logic [6*NDR-1:0]  req_blk_cnt,
   input  logic [NDR-1:0]    req_rd,
   input  logic [NDR-1:0]    req_wr,
   output logic [NDR-1:0]    req_ack,
   input  logic [8*NDR-1:0]  req_buff_din,
   output logic [31:0]       sd_lba,
   output logic [5:0]        sd_blk_cnt,
   output logic              sd_rd,
   output logic              sd_wr,
   input  logic              sd_ack,
   output logic [7:0]        sd_buff_din,
   output logic              busy,
   output logic [1:0]        grant,
   output logic              timeout
);

   if (TIMEOUT_W < 2) begin : g_bad_timeout_w
      $error("iec_sd_arbiter: TIMEOUT_W must be at least 2");
   end

   logic [31:0]           lbaLane  [MAX_DRIVES];
   logic [5:0]            blkLane  [MAX_DRIVES];
   logic [7:0]            buffLane [MAX_DRIVES];
   logic [MAX_DRIVES-1:0] rdPad;
   logic [MAX_DRIVES-1:0] wrPad;

   // Lanes beyond NDR read as idle so the picker and muxes always see four slots.
   for (genvar gi = 0; gi < MAX_DRIVES; gi++) begin : g_lane
      if (gi < NDR) begin : g_used
         assign lbaLane[gi]  = req_lba[gi*32 +: 32];
         assign blkLane[gi]  = req_blk_cnt[gi*6 +: 6];
         assign buffLane[gi] = req_buff_din[gi*8 +: 8];
         assign rdPad[gi]    = req_rd[gi];
         assign wrPad[gi]    = req_wr[gi];
      end else begin : g_pad
         assign lbaLane[gi]  = '0;
         assign blkLane[gi]  = '0;
         assign buffLane[gi] = '0;
         assign rdPad[gi]    = 1'b0;
         assign wrPad[gi]    = 1'b0;
      end
   end

   arb_state_e     state_q, state_d;
   logic [1:0]     grant_q, grant_d;
   logic [1:0]     rrPtr_q, rrPtr_d;
   logic [31:0]    sdLba_q, sdLba_d;
   logic [5:0]     sdBlkCnt_q, sdBlkCnt_d;
   logic           opWr_q, opWr_d;
   logic           sdRd_q, sdRd_d;
   logic           sdWr_q, sdWr_d;
   logic [NDR-1:0] reqAck_q, reqAck_d;
   logic           launch_q, launch_d;
   logic           ackPrev_q;

   logic           pickFound;
   logic [1:0]     pickIdx;
   logic           ackRise;
   logic           laneReq;
   logic [NDR-1:0] ackOneHot;
   logic [1:0]     nextPtr;

`ifdef IEC_SD_ARB_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] TMO_LAST = ~TIMEOUT_W'(1);
   logic [TIMEOUT_W-1:0] tmoCnt_q, tmoCnt_d;
   logic                 timeout_q, timeout_d;
   logic                 tmoHit;

   assign tmoHit  = (tmoCnt_q == TMO_LAST);
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   iec_sd_rr_picker #(
      .NDR(NDR)
   ) u_picker (
      .pending_i(rdPad | wrPad),
      .ptr_i    (rrPtr_q),
      .found_o  (pickFound),
      .idx_o    (pickIdx)
   );

   assign ackRise = sd_ack & ~ackPrev_q;
   assign laneReq = rdPad[grant_q] | wrPad[grant_q];
   assign nextPtr = (grant_q == 2'(NDR - 1)) ? 2'd0 : grant_q + 2'd1;

   always_comb begin
      ackOneHot = '0;
      for (int i = 0; i < NDR; i++) begin
         ackOneHot[i] = (grant_q == 2'(i));
      end
   end

   // Next-state logic: IDLE first latches the winner, then launches the strobe the following cycle.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rrPtr_d    = rrPtr_q;
      sdLba_d    = sdLba_q;
      sdBlkCnt_d = sdBlkCnt_q;
      opWr_d     = opWr_q;
      sdRd_d     = 1'b0;
      sdWr_d     = 1'b0;
      reqAck_d   = '0;
      launch_d   = 1'b0;
`ifdef IEC_SD_ARB_TIMEOUT_EN
      tmoCnt_d   = tmoCnt_q;
      timeout_d  = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (launch_q) begin
               state_d = REQ;
               sdRd_d  = ~opWr_q;
               sdWr_d  = opWr_q;
`ifdef IEC_SD_ARB_TIMEOUT_EN
               tmoCnt_d = '0;
`endif
            end else if (pickFound && !sd_ack) begin
               grant_d    = pickIdx;
               sdLba_d    = lbaLane[pickIdx];
               sdBlkCnt_d = blkLane[pickIdx];
               opWr_d     = wrPad[pickIdx];
               launch_d   = 1'b1;
            end
         end
         REQ: begin
            sdRd_d = sdRd_q;
            sdWr_d = sdWr_q;
`ifdef IEC_SD_ARB_TIMEOUT_EN
            tmoCnt_d = tmoCnt_q + TIMEOUT_W'(1);
`endif
            if (ackRise) begin
               sdRd_d   = 1'b0;
               sdWr_d   = 1'b0;
               reqAck_d = ackOneHot;
               state_d  = XFER;
            end else if (!laneReq) begin
               sdRd_d  = 1'b0;
               sdWr_d  = 1'b0;
               state_d = IDLE;
            end
`ifdef IEC_SD_ARB_TIMEOUT_EN
            else if (tmoHit) begin
               sdRd_d    = 1'b0;
               sdWr_d    = 1'b0;
               timeout_d = 1'b1;
               state_d   = REL;
            end
`endif
         end
         XFER: begin
            if (sd_ack) begin
               reqAck_d = ackOneHot;
            end else begin
               state_d = REL;
            end
         end
         REL: begin
            rrPtr_d = nextPtr;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset clears ackPrev_q so a stale host ack is held off by IDLE until it drops.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rrPtr_q    <= '0;
         sdLba_q    <= '0;
         sdBlkCnt_q <= '0;
         opWr_q     <= 1'b0;
         sdRd_q     <= 1'b0;
         sdWr_q     <= 1'b0;
         reqAck_q   <= '0;
         launch_q   <= 1'b0;
         ackPrev_q  <= 1'b0;
`ifdef IEC_SD_ARB_TIMEOUT_EN
         tmoCnt_q   <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rrPtr_q    <= rrPtr_d;
         sdLba_q    <= sdLba_d;
         sdBlkCnt_q <= sdBlkCnt_d;
         opWr_q     <= opWr_d;
         sdRd_q     <= sdRd_d;
         sdWr_q     <= sdWr_d;
         reqAck_q   <= reqAck_d;
         launch_q   <= launch_d;
         ackPrev_q  <= sd_ack;
`ifdef IEC_SD_ARB_TIMEOUT_EN
         tmoCnt_q   <= tmoCnt_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign sd_lba      = sdLba_q;
   assign sd_blk_cnt  = sdBlkCnt_q;
   assign sd_rd       = sdRd_q;
   assign sd_wr       = sdWr_q;
   assign req_ack     = reqAck_q;
   assign sd_buff_din = buffLane[grant_q];
   assign busy        = (state_q != IDLE);
   assign grant       = grant_q;

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// Directed self-checking bench for iec_sd_arbiter with four lanes.
// The watchdog scenario runs only when IEC_SD_ARB_TIMEOUT_EN is defined.
module tb_iec_sd_arbiter;

   logic         clk_sys = 1'b0;
   logic         reset;
   logic [127:0] req_lba;
   logic [23:0]  req_blk_cnt;
   logic [3:0]   req_rd;
   logic [3:0]   req_wr;
   logic [3:0]   req_ack;
   logic [31:0]  req_buff_din;
   logic [31:0]  sd_lba;
   logic [5:0]   sd_blk_cnt;
   logic         sd_rd;
   logic         sd_wr;
   logic         sd_ack;
   logic [7:0]   sd_buff_din;
   logic         busy;
   logic [1:0]   grant;
   logic         timeout;

   int checks   = 0;
   int failures = 0;

   iec_sd_arbiter #(
      .DRIVES   (4),
      .TIMEOUT_W(4)
   ) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .req_lba     (req_lba),
      .req_blk_cnt (req_blk_cnt),
      .req_rd      (req_rd),
      .req_wr      (req_wr),
      .req_ack     (req_ack),
      .req_buff_din(req_buff_din),
      .sd_lba      (sd_lba),
      .sd_blk_cnt  (sd_blk_cnt),
      .sd_rd       (sd_rd),
      .sd_wr       (sd_wr),
      .sd_ack      (sd_ack),
      .sd_buff_din (sd_buff_din),
      .busy        (busy),
      .grant       (grant),
      .timeout     (timeout)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
      end
   endtask

   task automatic stepClock(input int n);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic applyStimulus(input int lane, input logic rd, input logic wr, input logic [31:0] lba,
                                input logic [5:0] blk, input logic [7:0] buff);
      req_rd[lane]               = rd;
      req_wr[lane]               = wr;
      req_lba[lane*32 +: 32]     = lba;
      req_blk_cnt[lane*6 +: 6]   = blk;
      req_buff_din[lane*8 +: 8]  = buff;
   endtask

   task automatic dropRequest(input int lane);
      req_rd[lane] = 1'b0;
      req_wr[lane] = 1'b0;
   endtask

   task automatic waitStrobe(input string tag);
      int n;
      n = 0;
      while (!(sd_rd || sd_wr) && n < 20) begin
         stepClock(1);
         n++;
      end
      checkOutput({tag, "_strobe"}, 32'(sd_rd | sd_wr), 32'd1);
   endtask

   // Host acks for two cycles; optionally a new request from reLane arrives mid-transfer.
   task automatic finishTransfer(input int lane, input string tag, input int reLane, input logic [31:0] reLba);
      sd_ack = 1'b1;
      stepClock(1);
      checkOutput({tag, "_ack"}, 32'(req_ack), 32'd1 << lane);
      dropRequest(lane);
      if (reLane >= 0) applyStimulus(reLane, 1'b1, 1'b0, reLba, 6'd0, 8'd0);
      stepClock(1);
      sd_ack = 1'b0;
      stepClock(1);
      checkOutput({tag, "_ack_low"}, 32'(req_ack), 32'd0);
      stepClock(1);
   endtask

   task automatic doReset();
      reset = 1'b1;
      stepClock(1);
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset        = 1'b1;
      req_lba      = '0;
      req_blk_cnt  = '0;
      req_rd       = '0;
      req_wr       = '0;
      req_buff_din = '0;
      sd_ack       = 1'b0;
      stepClock(2);
      checkOutput("rst_sd_rd", 32'(sd_rd), 32'd0);
      checkOutput("rst_sd_wr", 32'(sd_wr), 32'd0);
      checkOutput("rst_req_ack", 32'(req_ack), 32'd0);
      checkOutput("rst_sd_lba", sd_lba, 32'd0);
      checkOutput("rst_blk_cnt", 32'(sd_blk_cnt), 32'd0);
      checkOutput("rst_grant", 32'(grant), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_timeout", 32'(timeout), 32'd0);
      reset = 1'b0;
      stepClock(1);

      $display("[TB] single read on lane 0");
      applyStimulus(0, 1'b1, 1'b0, 32'h165, 6'd7, 8'h00);
      stepClock(1);
      checkOutput("rd_lat1_sd_rd", 32'(sd_rd), 32'd0);
      stepClock(1);
      checkOutput("rd_sd_rd", 32'(sd_rd), 32'd1);
      checkOutput("rd_sd_wr", 32'(sd_wr), 32'd0);
      checkOutput("rd_sd_lba", sd_lba, 32'h165);
      checkOutput("rd_blk_cnt", 32'(sd_blk_cnt), 32'd7);
      checkOutput("rd_grant", 32'(grant), 32'd0);
      checkOutput("rd_busy", 32'(busy), 32'd1);
      sd_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         stepClock(1);
         checkOutput("rd_ack_fwd", 32'(req_ack), 32'd1);
         if (i == 0) begin
            checkOutput("rd_strobe_drop", 32'(sd_rd), 32'd0);
            dropRequest(0);
         end
      end
      sd_ack = 1'b0;
      stepClock(1);
      checkOutput("rd_ack_low", 32'(req_ack), 32'd0);
      checkOutput("rd_busy_rel", 32'(busy), 32'd1);
      stepClock(1);
      checkOutput("rd_busy_idle", 32'(busy), 32'd0);

      $display("[TB] round robin lanes 0,2,3");
      doReset();
      applyStimulus(0, 1'b1, 1'b0, 32'h1000, 6'd0, 8'd0);
      applyStimulus(2, 1'b1, 1'b0, 32'h1002, 6'd0, 8'd0);
      applyStimulus(3, 1'b1, 1'b0, 32'h1003, 6'd0, 8'd0);
      waitStrobe("rr0");
      checkOutput("rr0_grant", 32'(grant), 32'd0);
      checkOutput("rr0_lba", sd_lba, 32'h1000);
      finishTransfer(0, "rr0", -1, 32'd0);
      waitStrobe("rr2");
      checkOutput("rr2_grant", 32'(grant), 32'd2);
      checkOutput("rr2_lba", sd_lba, 32'h1002);
      finishTransfer(2, "rr2", 0, 32'h2000);
      waitStrobe("rr3");
      checkOutput("rr3_grant", 32'(grant), 32'd3);
      checkOutput("rr3_lba", sd_lba, 32'h1003);
      finishTransfer(3, "rr3", -1, 32'd0);
      waitStrobe("rr0b");
      checkOutput("rr0b_grant", 32'(grant), 32'd0);
      checkOutput("rr0b_lba", sd_lba, 32'h2000);
      finishTransfer(0, "rr0b", -1, 32'd0);

      $display("[TB] same-lane read+write on lane 1");
      req_buff_din[7:0] = 8'h3C;
      applyStimulus(1, 1'b1, 1'b1, 32'h3000, 6'd2, 8'hA5);
      waitStrobe("rw");
      checkOutput("rw_sd_wr", 32'(sd_wr), 32'd1);
      checkOutput("rw_sd_rd", 32'(sd_rd), 32'd0);
      checkOutput("rw_grant", 32'(grant), 32'd1);
      checkOutput("rw_buff", 32'(sd_buff_din), 32'hA5);
      req_buff_din[15:8] = 8'h5A;
      #1;
      checkOutput("rw_buff_track", 32'(sd_buff_din), 32'h5A);
      finishTransfer(1, "rw", -1, 32'd0);

      $display("[TB] cancel on lane 1");
      doReset();
      applyStimulus(1, 1'b1, 1'b0, 32'h4000, 6'd1, 8'd0);
      waitStrobe("cx");
      checkOutput("cx_grant", 32'(grant), 32'd1);
      dropRequest(1);
      stepClock(1);
      checkOutput("cx_sd_rd", 32'(sd_rd), 32'd0);
      checkOutput("cx_busy", 32'(busy), 32'd0);
      checkOutput("cx_req_ack", 32'(req_ack), 32'd0);
      applyStimulus(0, 1'b1, 1'b0, 32'h4100, 6'd0, 8'd0);
      applyStimulus(2, 1'b1, 1'b0, 32'h4200, 6'd0, 8'd0);
      waitStrobe("cx_ptr");
      checkOutput("cx_ptr_grant", 32'(grant), 32'd0);
      finishTransfer(0, "cx_ptr", -1, 32'd0);
      waitStrobe("cx_next");
      checkOutput("cx_next_grant", 32'(grant), 32'd2);
      finishTransfer(2, "cx_next", -1, 32'd0);

      $display("[TB] reset during transfer");
      applyStimulus(3, 1'b1, 1'b0, 32'h5000, 6'd9, 8'd0);
      waitStrobe("mr");
      checkOutput("mr_grant", 32'(grant), 32'd3);
      sd_ack = 1'b1;
      stepClock(1);
      checkOutput("mr_ack", 32'(req_ack), 32'h8);
      reset = 1'b1;
      stepClock(1);
      checkOutput("mr_sd_rd", 32'(sd_rd), 32'd0);
      checkOutput("mr_req_ack", 32'(req_ack), 32'd0);
      checkOutput("mr_sd_lba", sd_lba, 32'd0);
      checkOutput("mr_blk_cnt", 32'(sd_blk_cnt), 32'd0);
      checkOutput("mr_grant_rst", 32'(grant), 32'd0);
      checkOutput("mr_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      dropRequest(3);
      applyStimulus(1, 1'b1, 1'b0, 32'h6000, 6'd3, 8'd0);
      stepClock(4);
      checkOutput("mr_hold_strobe", 32'(sd_rd | sd_wr), 32'd0);
      checkOutput("mr_hold_ack", 32'(req_ack), 32'd0);
      checkOutput("mr_hold_busy", 32'(busy), 32'd0);
      checkOutput("mr_hold_grant", 32'(grant), 32'd0);
      sd_ack = 1'b0;
      waitStrobe("mr_after");
      checkOutput("mr_after_grant", 32'(grant), 32'd1);
      checkOutput("mr_after_lba", sd_lba, 32'h6000);
      finishTransfer(1, "mr_after", -1, 32'd0);

`ifdef IEC_SD_ARB_TIMEOUT_EN
      $display("[TB] ack watchdog");
      doReset();
      applyStimulus(0, 1'b1, 1'b0, 32'h7000, 6'd0, 8'd0);
      applyStimulus(1, 1'b1, 1'b0, 32'h7001, 6'd0, 8'd0);
      waitStrobe("tmo");
      checkOutput("tmo_grant", 32'(grant), 32'd0);
      stepClock(14);
      checkOutput("tmo_early", 32'(timeout), 32'd0);
      checkOutput("tmo_early_rd", 32'(sd_rd), 32'd1);
      stepClock(1);
      checkOutput("tmo_pulse", 32'(timeout), 32'd1);
      checkOutput("tmo_rd_low", 32'(sd_rd), 32'd0);
      checkOutput("tmo_no_ack", 32'(req_ack), 32'd0);
      dropRequest(0);
      stepClock(1);
      checkOutput("tmo_pulse_end", 32'(timeout), 32'd0);
      waitStrobe("tmo_next");
      checkOutput("tmo_next_grant", 32'(grant), 32'd1);
      finishTransfer(1, "tmo_next", -1, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
